// File: rtl/blake2_block_feeder.sv
// blake2_block_feeder
// Packs a valid/ready byte stream into 1024-bit BLAKE2 blocks and drives the
// hash core's command interface (init / next / final pulses).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   byte stream in, s_last marks final byte
//   core_ready         downstream accepts a command this cycle
//   init, next         one-cycle pulses with first / subsequent block
//   final_pulse        one-cycle pulse, message complete ("final" is reserved)
//   block, length      packed block (first byte in [1023:1016]) and byte count
//   overflow           sticky, message exceeded MAX_BLOCKS blocks
//   busy               message partially received or command pending
module blake2_block_feeder #(
  parameter int unsigned MAX_BLOCKS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  input  logic          core_ready,
  output logic          init,
  output logic          next,
  output logic          final_pulse,
  output logic [1023:0] block,
  output logic [127:0]  length,
  output logic          overflow,
  output logic          busy
);

  localparam int unsigned BlkW = $clog2(MAX_BLOCKS + 1);

  typedef enum logic [1:0] {StFill, StIssue, StFinal, StDrain} state_e;

  state_e          state_q, state_d;
  logic [1023:0]   wbuf_q, wbuf_d, block_d;
  logic [6:0]      bcnt_q, bcnt_d;
  logic [BlkW-1:0] blk_q, blk_d;
  logic [127:0]    tot_q, tot_d, length_d;
  logic            last_seen_q, last_seen_d;
  logic            first_q, first_d;
  logic            init_d, next_d, final_d, overflow_d, s_ready_d, busy_d;
  logic            accept;
  logic [9:0]      wpos;

  assign accept = s_valid && s_ready;
  // Top bit of the byte slot selected by bcnt.
  assign wpos   = 10'd1023 - {bcnt_q, 3'b000};

  always_comb begin
    state_d     = state_q;
    wbuf_d      = wbuf_q;
    bcnt_d      = bcnt_q;
    blk_d       = blk_q;
    tot_d       = tot_q;
    last_seen_d = last_seen_q;
    first_d     = first_q;
    block_d     = block;
    length_d    = length;
    overflow_d  = overflow;
    init_d      = 1'b0;
    next_d      = 1'b0;
    final_d     = 1'b0;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          wbuf_d[wpos -: 8] = s_data;
          bcnt_d            = bcnt_q + 7'd1;
          tot_d             = tot_q + 128'd1;
          if (bcnt_q == 7'd127 || s_last) begin
            state_d     = StIssue;
            last_seen_d = s_last;
          end
        end
      end
      StIssue: begin
        if (core_ready) begin
          block_d  = wbuf_q;
          length_d = tot_q;
          init_d   = first_q;
          next_d   = !first_q;
          blk_d    = blk_q + 1'b1;
          first_d  = 1'b0;
          wbuf_d   = '0;
          bcnt_d   = '0;
          if (last_seen_q) begin
            state_d = StFinal;
          end else if (blk_q == BlkW'(MAX_BLOCKS - 1)) begin
            // Buffer full but message continues: swallow the rest of it.
            state_d    = StDrain;
            overflow_d = 1'b1;
          end else begin
            state_d = StFill;
          end
        end
      end
      StFinal: begin
        if (core_ready) begin
          final_d = 1'b1;
          blk_d   = '0;
          tot_d   = '0;
          first_d = 1'b1;
          state_d = StFill;
        end
      end
      StDrain: begin
        if (accept && s_last) begin
          blk_d   = '0;
          tot_d   = '0;
          bcnt_d  = '0;
          first_d = 1'b1;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase

    // Outputs are registered, so derive them from the next-state values.
    s_ready_d = (state_d == StFill) || (state_d == StDrain);
    busy_d    = (state_d != StFill) || (bcnt_d != 7'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFill;
      wbuf_q      <= '0;
      bcnt_q      <= '0;
      blk_q       <= '0;
      tot_q       <= '0;
      last_seen_q <= 1'b0;
      first_q     <= 1'b1;
      block       <= '0;
      length      <= '0;
      overflow    <= 1'b0;
      init        <= 1'b0;
      next        <= 1'b0;
      final_pulse <= 1'b0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wbuf_q      <= wbuf_d;
      bcnt_q      <= bcnt_d;
      blk_q       <= blk_d;
      tot_q       <= tot_d;
      last_seen_q <= last_seen_d;
      first_q     <= first_d;
      block       <= block_d;
      length      <= length_d;
      overflow    <= overflow_d;
      init        <= init_d;
      next        <= next_d;
      final_pulse <= final_d;
      s_ready     <= s_ready_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_blake2_block_feeder.sv
// Directed testbench for blake2_block_feeder: byte messages in, pulse counts
// and captured block/length values checked against hand-built expectations.
module tb_blake2_block_feeder;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          core_ready = 1'b1;
  logic          init, next, final_pulse;
  logic [1023:0] block;
  logic [127:0]  length;
  logic          overflow, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse monitor state (written only by the monitor process).
  int            n_init = 0, n_next = 0, n_final = 0, n_multi = 0;
  logic [1023:0] init_blk, next_blk;
  logic [127:0]  init_len, next_len, final_len;

  blake2_block_feeder #(.MAX_BLOCKS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .core_ready (core_ready),
    .init       (init),
    .next       (next),
    .final_pulse(final_pulse),
    .block      (block),
    .length     (length),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Sees the pre-edge values, i.e. the cycle that just ended.
  always @(posedge clk) begin
    if (int'(init) + int'(next) + int'(final_pulse) > 1) n_multi++;
    if (init)        begin n_init++;  init_blk <= block; init_len <= length; end
    if (next)        begin n_next++;  next_blk <= block; next_len <= length; end
    if (final_pulse) begin n_final++; final_len <= length; end
  end

  // Called at a negedge; returns at the negedge after the last accepted byte.
  task automatic send_msg(input int n, input int base, input bit with_last);
    int guard;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(base + i);
      s_last  = with_last && (i == n - 1);
      guard   = 0;
      while (s_ready !== 1'b1 && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: s_ready low for %0d cycles, required 1", guard);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    int guard = 0;
    while (busy !== 1'b0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    timed_out = (guard >= 2000);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    n_cmp++; if ({init, next, final_pulse} !== 3'b000) begin
      n_bad++; $display("FAIL rst_pulses: got %b want 000", {init, next, final_pulse}); end
    n_cmp++; if (block !== '0 || length !== '0) begin
      n_bad++; $display("FAIL rst_block_len: got len %0d, block nonzero=%b", length, |block); end
    n_cmp++; if ({overflow, busy} !== 2'b00) begin
      n_bad++; $display("FAIL rst_ovf_busy: got %b want 00", {overflow, busy}); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", s_ready); end
  endtask

  task automatic test_abc;
    int bi = n_init, bn = n_next, bf = n_final;
    bit to;
    logic [1023:0] exp = '0;
    exp[1023:1000] = 24'h616263;
    send_msg(3, 'h61, 1'b1);
    n_cmp++; if (init !== 1'b0 || s_ready !== 1'b0) begin
      n_bad++; $display("FAIL abc_issue_cycle: init %b s_ready %b want 0 0", init, s_ready); end
    @(negedge clk);
    n_cmp++; if (init !== 1'b1) begin n_bad++; $display("FAIL abc_init_latency: init %b want 1", init); end
    @(negedge clk);
    n_cmp++; if ({init, final_pulse} !== 2'b01) begin
      n_bad++; $display("FAIL abc_final_next: init,final %b want 01", {init, final_pulse}); end
    wait_idle(to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL abc_idle: busy stuck 1, want 0"); end
    n_cmp++; if (n_init - bi != 1 || n_next - bn != 0 || n_final - bf != 1) begin
      n_bad++; $display("FAIL abc_counts: init %0d next %0d final %0d want 1 0 1",
                        n_init - bi, n_next - bn, n_final - bf); end
    n_cmp++; if (init_blk !== exp) begin
      n_bad++; $display("FAIL abc_block: got %h want 616263 then zeros", init_blk[1023:992]); end
    n_cmp++; if (init_len !== 128'd3 || final_len !== 128'd3) begin
      n_bad++; $display("FAIL abc_len: init %0d final %0d want 3 3", init_len, final_len); end
  endtask

  task automatic test_full_block;
    int bi = n_init, bn = n_next, bf = n_final;
    bit to;
    logic [1023:0] exp;
    for (int i = 0; i < 128; i++) exp[1023 - 8 * i -: 8] = 8'(i);
    send_msg(128, 0, 1'b1);
    wait_idle(to);
    n_cmp++; if (to || n_init - bi != 1 || n_next - bn != 0 || n_final - bf != 1) begin
      n_bad++; $display("FAIL full_counts: init %0d next %0d final %0d timeout %b want 1 0 1 0",
                        n_init - bi, n_next - bn, n_final - bf, to); end
    n_cmp++; if (init_blk !== exp) begin
      n_bad++; $display("FAIL full_block: first %h last %h want 00 7f", init_blk[1023:1016], init_blk[7:0]); end
    n_cmp++; if (init_len !== 128'd128 || final_len !== 128'd128) begin
      n_bad++; $display("FAIL full_len: init %0d final %0d want 128 128", init_len, final_len); end
  endtask

  task automatic test_129;
    int bi = n_init, bn = n_next, bf = n_final;
    bit to;
    logic [1023:0] exp = '0;
    exp[1023:1016] = 8'h80;
    send_msg(129, 0, 1'b1);
    wait_idle(to);
    n_cmp++; if (to || n_init - bi != 1 || n_next - bn != 1 || n_final - bf != 1) begin
      n_bad++; $display("FAIL b129_counts: init %0d next %0d final %0d timeout %b want 1 1 1 0",
                        n_init - bi, n_next - bn, n_final - bf, to); end
    n_cmp++; if (init_len !== 128'd128) begin n_bad++; $display("FAIL b129_init_len: got %0d want 128", init_len); end
    n_cmp++; if (next_blk !== exp) begin
      n_bad++; $display("FAIL b129_next_block: first %h want 80, rest nonzero=%b", next_blk[1023:1016], |next_blk[1015:0]); end
    n_cmp++; if (next_len !== 128'd129 || final_len !== 128'd129) begin
      n_bad++; $display("FAIL b129_len: next %0d final %0d want 129 129", next_len, final_len); end
  endtask

  task automatic test_stall;
    int bi = n_init, bf = n_final;
    bit to;
    core_ready = 1'b0;
    send_msg(5, 'h10, 1'b1);
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (s_ready !== 1'b0 || {init, next, final_pulse} !== 3'b000) begin
        n_bad++; $display("FAIL stall_cycle%0d: s_ready %b pulses %b want 0 000", c, s_ready,
                          {init, next, final_pulse}); end
      @(negedge clk);
    end
    core_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (init !== 1'b1) begin n_bad++; $display("FAIL stall_release: init %b want 1", init); end
    @(negedge clk);
    n_cmp++; if (init !== 1'b0) begin n_bad++; $display("FAIL stall_width: init %b want 0", init); end
    wait_idle(to);
    n_cmp++; if (to || n_init - bi != 1 || n_final - bf != 1 || init_len !== 128'd5) begin
      n_bad++; $display("FAIL stall_counts: init %0d final %0d len %0d want 1 1 5",
                        n_init - bi, n_final - bf, init_len); end
  endtask

  task automatic test_overflow;
    int bi = n_init, bn = n_next, bf = n_final;
    bit to;
    logic [1023:0] exp;
    for (int i = 0; i < 128; i++) exp[1023 - 8 * i -: 8] = 8'(128 + i);
    send_msg(1100, 0, 1'b1);
    wait_idle(to);
    n_cmp++; if (to || n_init - bi != 1 || n_next - bn != 7 || n_final - bf != 0) begin
      n_bad++; $display("FAIL ovf_counts: init %0d next %0d final %0d timeout %b want 1 7 0 0",
                        n_init - bi, n_next - bn, n_final - bf, to); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (next_blk !== exp || next_len !== 128'd1024) begin
      n_bad++; $display("FAIL ovf_last_block: first %h len %0d want 80 1024", next_blk[1023:1016], next_len); end
    bi = n_init; bf = n_final;
    send_msg(1, 'h5a, 1'b1);
    wait_idle(to);
    n_cmp++; if (to || n_init - bi != 1 || n_final - bf != 1 || final_len !== 128'd1) begin
      n_bad++; $display("FAIL ovf_recover: init %0d final %0d len %0d want 1 1 1",
                        n_init - bi, n_final - bf, final_len); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid;
    int bi, bf;
    bit to;
    logic [1023:0] exp = '0;
    exp[1023:1016] = 8'h33;
    send_msg(50, 'h40, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({s_ready, init, next, final_pulse, overflow, busy} !== 6'b0 ||
                 block !== '0 || length !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: flags %b len %0d want 000000 0",
                        {s_ready, init, next, final_pulse, overflow, busy}, length); end
    reset = 1'b0;
    @(negedge clk);
    bi = n_init; bf = n_final;
    send_msg(1, 'h33, 1'b1);
    wait_idle(to);
    n_cmp++; if (to || n_init - bi != 1 || n_final - bf != 1 || init_len !== 128'd1 || init_blk !== exp) begin
      n_bad++; $display("FAIL mid_new_msg: init %0d final %0d len %0d byte %h want 1 1 1 33",
                        n_init - bi, n_final - bf, init_len, init_blk[1023:1016]); end
    n_cmp++; if (n_multi != 0) begin n_bad++; $display("FAIL pulse_overlap: %0d cycles, want 0", n_multi); end
  endtask

  initial begin
    test_reset;
    test_abc;
    test_full_block;
    test_129;
    test_stall;
    test_overflow;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
